// File: rtl/cnn_result_collector.sv
// Result collector for the CNN engine: edge-detects eng_done, queues {img_idx, class} records,
// and tracks sticky errors. Define RESULT_HIST_EN to build the per-class saturating histogram.
module cnn_result_collector #(
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 16,
    parameter int NUM_CLASSES = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     eng_done,
    input  logic [3:0]               eng_class,
    input  logic [4:0]               eng_img_idx,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [8:0]               rd_data,
    output logic                     fifo_empty,
    output logic                     fifo_full,
    output logic [$clog2(DEPTH):0]   fifo_count,
    input  logic                     clear,
    input  logic [3:0]               hist_sel,
    output logic [CNT_W-1:0]         hist_count,
    output logic                     ovf_err,
    output logic                     cls_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [3:0]    NUM_CLS_C = 4'(NUM_CLASSES);

    logic           clr;
    logic           push_evt;
    logic           cls_ok;
    logic           pop_ok;
    logic           push_ok;
    logic           drop;

    logic           prev_done_q;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           empty_q, full_q;
    logic           rd_valid_q;
    logic [8:0]     rd_data_q;
    logic           ovf_q, cls_q;
    logic [8:0]     mem [DEPTH];

    assign clr      = reset | clear;
    assign push_evt = eng_done & ~prev_done_q;
    assign cls_ok   = (eng_class < NUM_CLS_C);
    assign pop_ok   = rd_en & (count_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok  = push_evt & cls_ok & (~full_q | pop_ok);
    assign drop     = push_evt & cls_ok & full_q & ~pop_ok;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            prev_done_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            ovf_q       <= 1'b0;
            cls_q       <= 1'b0;
        end else begin
            prev_done_q <= eng_done;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            empty_q     <= (count_d == '0);
            full_q      <= (count_d == DEPTH_C);
            rd_valid_q  <= pop_ok;
            if (pop_ok) rd_data_q <= mem[rd_ptr_q];
            if (drop) ovf_q <= 1'b1;
            if (push_evt && !cls_ok) cls_q <= 1'b1;
        end
    end

    // Storage has no reset so it maps onto block RAM; the read above sees the pre-write value.
    always_ff @(posedge clk) begin
        if (push_ok && !clr) mem[wr_ptr_q] <= {eng_img_idx, eng_class};
    end

    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign fifo_empty = empty_q;
    assign fifo_full  = full_q;
    assign fifo_count = count_q;
    assign ovf_err    = ovf_q;
    assign cls_err    = cls_q;

`ifdef RESULT_HIST_EN
    logic                hist_hit;
    logic [CNT_W-1:0]    cnt_vec [NUM_CLASSES];
    logic [CNT_W-1:0]    hist_d;
    logic [CNT_W-1:0]    hist_q;

    // Dropped results still count; only invalid class codes are excluded.
    assign hist_hit = push_evt & cls_ok;

    generate
        for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_cls
            logic [CNT_W-1:0] cnt_q;
            always_ff @(posedge clk) begin
                if (clr) begin
                    cnt_q <= '0;
                end else if (hist_hit && (eng_class == 4'(gi)) && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
            assign cnt_vec[gi] = cnt_q;
        end
    endgenerate

    always_comb begin
        hist_d = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (hist_sel == 4'(i)) hist_d = cnt_vec[i];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) hist_q <= '0;
        else     hist_q <= hist_d;
    end

    assign hist_count = hist_q;
`else
    logic unused_hist_sel;
    assign unused_hist_sel = ^hist_sel;
    assign hist_count      = '0;
`endif

endmodule

// File: tb/tb_cnn_result_collector.sv
// Directed self-checking bench for cnn_result_collector (DEPTH=8, CNT_W=4).
module tb_cnn_result_collector;

    localparam int CNT_W = 4;
`ifdef RESULT_HIST_EN
    localparam bit HIST = 1'b1;
`else
    localparam bit HIST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, eng_done, rd_en, clear;
    logic [3:0]  eng_class, hist_sel;
    logic [4:0]  eng_img_idx;
    logic        rd_valid, fifo_empty, fifo_full, ovf_err, cls_err;
    logic [8:0]  rd_data;
    logic [3:0]  fifo_count;
    logic [CNT_W-1:0] hist_count;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    cnn_result_collector #(.DEPTH(8), .CNT_W(CNT_W), .NUM_CLASSES(10)) dut (
        .clk(clk), .reset(reset), .eng_done(eng_done), .eng_class(eng_class),
        .eng_img_idx(eng_img_idx), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count),
        .clear(clear), .hist_sel(hist_sel), .hist_count(hist_count),
        .ovf_err(ovf_err), .cls_err(cls_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] cls, input logic [4:0] idx);
        eng_class = cls; eng_img_idx = idx; eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        step();
    endtask

    function automatic logic [31:0] hexp(input int v);
        return HIST ? 32'(v) : 32'd0;
    endfunction

    task automatic read_hist(input logic [3:0] sel, input int v, input string tag);
        hist_sel = sel;
        step();
        check(tag, 32'(hist_count), hexp(v));
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; eng_done = 1'b0; rd_en = 1'b0;
        eng_class = '0; eng_img_idx = '0; hist_sel = '0;
        step(); step();
        reset = 1'b0;
        check("rst_empty", 32'(fifo_empty), 32'd1);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_ovf", 32'(ovf_err), 32'd0);
        check("rst_cls", 32'(cls_err), 32'd0);
        for (int s = 0; s < 16; s++) read_hist(4'(s), 0, "rst_hist");
        $display("reset checks done");

        // Held level: exactly one push
        eng_class = 4'd3; eng_img_idx = 5'd7; eng_done = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("held_count", 32'(fifo_count), 32'd1);
        end
        eng_done = 1'b0; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("pop_valid", 32'(rd_valid), 32'd1);
        check("pop_data", 32'(rd_data), 32'h073);
        check("pop_empty", 32'(fifo_empty), 32'd1);
        step();
        check("pop_valid_drop", 32'(rd_valid), 32'd0);
        read_hist(4'd3, 1, "hist_cls3");
        $display("single push/pop: data=0x%0h", rd_data);

        // Overflow: 9 pushes, classes 0..8
        for (int i = 0; i < 9; i++) push(4'(i), 5'(i + 16));
        check("ovf_full", 32'(fifo_full), 32'd1);
        check("ovf_count", 32'(fifo_count), 32'd8);
        check("ovf_err", 32'(ovf_err), 32'd1);
        read_hist(4'd8, 1, "hist_cls8");
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("drain_valid", 32'(rd_valid), 32'd1);
            check("drain_data", 32'(rd_data), 32'({5'(i + 16), 4'(i)}));
            $display("drain %0d: data=0x%0h", i, rd_data);
        end
        step();
        rd_en = 1'b0;
        check("empty_pop_valid", 32'(rd_valid), 32'd0);
        check("empty_pop_hold", 32'(rd_data), 32'({5'd23, 4'd7}));
        check("drain_empty", 32'(fifo_empty), 32'd1);

        clear = 1'b1; step(); clear = 1'b0;
        check("clr_ovf", 32'(ovf_err), 32'd0);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) push(4'(i), 5'(i));
        check("sim_pre_count", 32'(fifo_count), 32'd8);
        eng_class = 4'd9; eng_img_idx = 5'd31; eng_done = 1'b1; rd_en = 1'b1;
        step();
        eng_done = 1'b0;
        check("sim_count", 32'(fifo_count), 32'd8);
        check("sim_ovf", 32'(ovf_err), 32'd0);
        check("sim_first", 32'(rd_data), 32'h000);
        for (int i = 1; i < 9; i++) begin
            step();
            check("sim_drain", 32'(rd_data),
                  (i == 8) ? 32'({5'd31, 4'd9}) : 32'({5'(i), 4'(i)}));
            $display("sim drain %0d: data=0x%0h", i, rd_data);
        end
        rd_en = 1'b0;
        step();
        check("sim_empty", 32'(fifo_empty), 32'd1);

        // Invalid class, then clear
        push(4'd2, 5'd5);
        push(4'd12, 5'd6);
        check("cls_err", 32'(cls_err), 32'd1);
        check("cls_count", 32'(fifo_count), 32'd1);
        read_hist(4'd2, 2, "hist_cls2");
        clear = 1'b1; step(); clear = 1'b0;
        check("clr_count", 32'(fifo_count), 32'd0);
        check("clr_empty", 32'(fifo_empty), 32'd1);
        check("clr_cls", 32'(cls_err), 32'd0);
        check("clr_rd_data", 32'(rd_data), 32'd0);
        check("clr_hist_q", 32'(hist_count), 32'd0);
        read_hist(4'd2, 0, "clr_hist2");
        read_hist(4'd3, 0, "clr_hist3");
        $display("invalid class and clear done");

        // Saturation: 20 pushes of class 5, popped immediately
        for (int i = 0; i < 20; i++) begin
            eng_class = 4'd5; eng_img_idx = 5'(i); eng_done = 1'b1;
            step();
            eng_done = 1'b0; rd_en = 1'b1;
            step();
            rd_en = 1'b0;
        end
        read_hist(4'd5, 15, "hist_sat");
        read_hist(4'd12, 0, "hist_sel_oor");
        check("sat_ovf", 32'(ovf_err), 32'd0);
        check("sat_empty", 32'(fifo_empty), 32'd1);
        $display("saturation: hist5=%0d", dut.hist_count);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/cnn_result_collector.md
Name: cnn_result_collector

Overview:
- Downstream of the CIFAR-10 CNN accelerator engine; consumes its `predicted_class`/`done` result.
- Detects each new completed classification and pushes an {image_index, class} record into a small FIFO for the RISC-V core to drain.
- Keeps per-class saturating hit counters and sticky error flags, so software can batch-read results without polling the engine every inference.

Parameters:
- DEPTH, 8, FIFO entries (power of two, ≥2)
- CNT_W, 16, width of each per-class histogram counter
- NUM_CLASSES, 10, valid class codes 0..NUM_CLASSES-1

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- eng_done  in  1  engine done level; held high while the engine sits in FINISH
- eng_class  in  4  engine predicted_class
- eng_img_idx  in  5  image index that accompanied the inference
- rd_en  in  1  pop request from the core
- rd_valid  out  1  rd_data is valid this cycle
- rd_data  out  9  {img_idx[8:4], class[3:0]}
- fifo_empty  out  1  FIFO holds 0 entries
- fifo_full  out  1  FIFO holds DEPTH entries
- fifo_count  out  $clog2(DEPTH)+1  current occupancy
- clear  in  1  synchronous soft clear of FIFO, counters and flags
- hist_sel  in  4  histogram class select
- hist_count  out  CNT_W  registered counter value for hist_sel
- ovf_err  out  1  sticky: a result was dropped because the FIFO was full
- cls_err  out  1  sticky: a class code ≥ NUM_CLASSES was received

Behaviour:
- Reset and clear are equivalent. Both set:
  - all FIFO pointers and fifo_count to 0; fifo_empty=1, fifo_full=0
  - rd_valid=0, rd_data=0
  - all histogram counters to 0; hist_count=0
  - ovf_err=0, cls_err=0
  - edge-detect register to 0
- Reset or clear mid-operation aborts any in-flight push/pop that cycle; nothing is written.
- Capture:
  - A push event is the rising edge of eng_done (eng_done=1 and registered prev=0).
  - eng_class and eng_img_idx are sampled in that same cycle.
  - A level held high never produces a second push.
- Class check:
  - If eng_class ≥ NUM_CLASSES, set cls_err; no FIFO write and no counter update.
- Push:
  - If the FIFO is not full, or a pop occurs in the same cycle, write the entry at wr_ptr and increment wr_ptr (mod DEPTH).
  - Otherwise drop the entry and set ovf_err. The histogram still counts the dropped result.
- Pop:
  - rd_en with FIFO non-empty: rd_data is loaded from rd_ptr and rd_valid=1 on the next cycle; rd_ptr increments.
  - rd_en with FIFO empty: ignored; rd_valid=0 next cycle and rd_data holds its value.
  - Without rd_en, rd_valid=0 next cycle.
- Simultaneous push and pop:
  - Non-empty FIFO: both proceed; count unchanged.
  - Empty FIFO: the pop is ignored and the push proceeds; count becomes 1.
  - Full FIFO: both proceed and nothing is dropped.
- Flags:
  - fifo_count, fifo_empty and fifo_full are registered and reflect state after the current cycle's operations.
  - Pointers wrap modulo DEPTH.
- Histogram:
  - Counter[eng_class] increments on each valid push event and saturates at 2^CNT_W−1.
  - hist_count is counter[hist_sel] registered with 1-cycle latency.
  - hist_sel ≥ NUM_CLASSES returns 0.
- Sticky errors clear only on reset or clear.

Optional Feature:
- Macro: RESULT_HIST_EN.
- Defined: the histogram counters and hist_count logic are built as described above.
- Undefined: no counters are instantiated and hist_count is tied to 0.
  - FIFO, flags and errors are unchanged.
  - hist_sel is ignored.

Test Plan:
- Reset, then check outputs:
  - Required: fifo_empty=1, fifo_count=0, rd_valid=0, ovf_err=0, cls_err=0, hist_count=0 for every hist_sel.
- Single push, held level, then pop:
  - Stimulus: eng_done held high 5 cycles with eng_class=3, eng_img_idx=7, then rd_en for 1 cycle.
  - Required: fifo_count goes to 1 once and stays there; rd_valid=1 one cycle after rd_en with rd_data=0x073; fifo_empty=1 afterwards; histogram class 3 reads 1.
- Overflow:
  - Stimulus: 9 eng_done pulses with classes 0..8, no reads.
  - Required: fifo_full=1, fifo_count=8, ovf_err=1.
  - Draining returns classes 0..7 in order; class 8 is absent from the FIFO; histogram class 8 reads 1.
- Simultaneous events:
  - Stimulus: with the FIFO full (8 entries), assert rd_en in the same cycle as an eng_done rising edge.
  - Required: count stays 8, ovf_err stays 0, and the new entry is drained last.
- Invalid class and clear:
  - Stimulus: eng_class=12 pushed.
  - Required: cls_err=1, fifo_count unchanged.
  - Then pulse clear: all flags, counts and counters return to 0.
- Saturation:
  - Stimulus: CNT_W=4 with 20 pushes of class 5, draining as needed.
  - Required: hist_count at hist_sel=5 reads 15.
  - Build with RESULT_HIST_EN undefined: hist_count reads 0 throughout.
